// File: rtl/byte_stream_sequencer_if.sv
// rtl/byte_stream_sequencer_if.sv - word intake handshake for the byte stream sequencer
interface byte_stream_sequencer_if #(
    parameter int NUM_BYTES = 4
);
    logic [8*NUM_BYTES-1:0] in_data;
    logic                   in_valid;
    logic                   in_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );
endinterface

// File: rtl/byte_stream_sequencer.sv
// rtl/byte_stream_sequencer.sv - feeds a captured word to the bit serializer byte by byte
// with a gap slot and an ACK slot per byte; stops early on NACK.
module byte_stream_sequencer #(
    parameter int NUM_BYTES = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    byte_stream_sequencer_if.slave  word_if,
    input  logic                    ack_in,
    input  logic                    abort,
    output logic                    tx_enable,
    output logic [7:0]              tx_byte,
    output logic                    sda_oe,
    output logic                    busy,
    output logic                    done,
    output logic                    nacked
);

    localparam int W     = 8 * NUM_BYTES;
    localparam int IDX_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP,
        ACK
    } state_t;

    state_t           state_q, state_d;
    logic [W-1:0]     word_q, word_d;
    logic [W-1:0]     word_shl;
    logic [2:0]       bit_q, bit_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             tx_enable_d;
    logic [7:0]       tx_byte_d;
    logic             done_d;
    logic             nacked_d;

    // The serializer shifts out bit 0 first, so reversing puts data bit 7 on the wire first.
    function automatic logic [7:0] wire_order(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = MSB_FIRST ? b[7-i] : b[i];
        end
        return r;
    endfunction

    assign word_if.in_ready = (state_q == IDLE);
    assign busy             = (state_q != IDLE);

    always_comb begin
        state_d     = state_q;
        word_d      = word_q;
        bit_d       = bit_q;
        idx_d       = idx_q;
        tx_enable_d = 1'b0;
        tx_byte_d   = tx_byte;
        done_d      = 1'b0;
        nacked_d    = 1'b0;
        word_shl    = word_q << 8;

        case (state_q)
            IDLE: begin
                if (word_if.in_valid) begin
                    state_d     = SEND;
                    word_d      = word_if.in_data;
                    idx_d       = '0;
                    bit_d       = 3'd0;
                    tx_enable_d = 1'b1;
                    tx_byte_d   = wire_order(word_if.in_data[W-1 -: 8]);
                end
            end
            SEND: begin
                tx_enable_d = 1'b1;
                bit_d       = bit_q + 3'd1;
                if (bit_q == 3'd7) begin
                    state_d     = GAP;
                    tx_enable_d = 1'b0;
                    bit_d       = 3'd0;
                end
            end
            GAP: begin
                state_d = ACK;
            end
            ACK: begin
                if (ack_in) begin
                    state_d  = IDLE;
                    done_d   = 1'b1;
                    nacked_d = 1'b1;
                end else if (idx_q == LAST_IDX) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    // Current byte always sits at the top of word_q; shift the next one up.
                    state_d     = SEND;
                    idx_d       = idx_q + IDX_W'(1);
                    word_d      = word_shl;
                    tx_enable_d = 1'b1;
                    tx_byte_d   = wire_order(word_shl[W-1 -: 8]);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || abort) begin
            state_q   <= IDLE;
            word_q    <= '0;
            bit_q     <= 3'd0;
            idx_q     <= '0;
            tx_enable <= 1'b0;
            tx_byte   <= 8'h00;
            sda_oe    <= 1'b0;
            done      <= 1'b0;
            nacked    <= 1'b0;
        end else begin
            state_q   <= state_d;
            word_q    <= word_d;
            bit_q     <= bit_d;
            idx_q     <= idx_d;
            tx_enable <= tx_enable_d;
            tx_byte   <= tx_byte_d;
            // The serializer output is registered, so the last bit stays on the wire through GAP.
            sda_oe    <= tx_enable;
            done      <= done_d;
            nacked    <= nacked_d;
        end
    end

endmodule

// File: tb/tb_byte_stream_sequencer.sv
// tb/tb_byte_stream_sequencer.sv - directed self-checking bench for byte_stream_sequencer
module tb_byte_stream_sequencer;

    logic clk = 1'b0;
    logic reset;
    logic ack_in;
    logic abort;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    byte_stream_sequencer_if #(.NUM_BYTES(4)) ifa ();
    byte_stream_sequencer_if #(.NUM_BYTES(4)) ifb ();

    logic       a_tx_enable, a_sda_oe, a_busy, a_done, a_nacked;
    logic [7:0] a_tx_byte;
    logic       b_tx_enable, b_sda_oe, b_busy, b_done, b_nacked;
    logic [7:0] b_tx_byte;

    byte_stream_sequencer #(.NUM_BYTES(4), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .reset(reset), .word_if(ifa.slave), .ack_in(ack_in), .abort(abort),
        .tx_enable(a_tx_enable), .tx_byte(a_tx_byte), .sda_oe(a_sda_oe),
        .busy(a_busy), .done(a_done), .nacked(a_nacked)
    );

    byte_stream_sequencer #(.NUM_BYTES(4), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .reset(reset), .word_if(ifb.slave), .ack_in(ack_in), .abort(abort),
        .tx_enable(b_tx_enable), .tx_byte(b_tx_byte), .sda_oe(b_sda_oe),
        .busy(b_busy), .done(b_done), .nacked(b_nacked)
    );

    // Serializer model: bit 0 first, one-cycle registered output, count cleared when disabled.
    logic       ser_out = 1'b0;
    logic [2:0] ser_cnt = 3'd0;
    always @(posedge clk) begin
        if (!a_tx_enable) begin
            ser_cnt <= 3'd0;
        end else begin
            ser_out <= a_tx_byte[ser_cnt];
            ser_cnt <= ser_cnt + 3'd1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put_word(input logic [31:0] d, input logic v);
        ifa.in_data  = d;
        ifa.in_valid = v;
        ifb.in_data  = d;
        ifb.in_valid = v;
    endtask

    task automatic clear_with_abort();
        abort = 1'b1;
        step();
        abort = 1'b0;
    endtask

    task automatic test_reset();
        logic [13:0] obs;
        reset  = 1'b1;
        abort  = 1'b0;
        ack_in = 1'b0;
        put_word(32'h0, 1'b0);
        step();
        step();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            obs = {ifa.in_ready, a_tx_enable, a_tx_byte, a_sda_oe, a_busy, a_done, a_nacked};
            tests++;
            if (obs !== 14'b1_0_00000000_0_0_0_0) begin
                fails++;
                $display("FAIL reset_idle[%0d]: got %b required %b", i, obs, 14'b1_0_00000000_0_0_0_0);
            end
        end
    endtask

    task automatic test_msb_order();
        logic [7:0]  exp_byte [4];
        logic [31:0] wire_bits;
        int          nbits;
        logic        en_exp, sda_exp;
        exp_byte[0] = 8'h81; exp_byte[1] = 8'h38; exp_byte[2] = 8'hB9; exp_byte[3] = 8'hA3;
        wire_bits = 32'h0;
        nbits     = 0;
        put_word(32'h811C9DC5, 1'b1);
        step();
        put_word(32'h811C9DC5, 1'b0);
        for (int k = 0; k <= 40; k++) begin
            en_exp  = (k < 40) && ((k % 10) < 8);
            sda_exp = (k < 40) && ((k % 10) >= 1) && ((k % 10) <= 8);
            tests++;
            if (a_tx_enable !== en_exp) begin
                fails++;
                $display("FAIL msb_tx_enable c%0d: got %b required %b", k, a_tx_enable, en_exp);
            end
            if (en_exp) begin
                tests++;
                if (a_tx_byte !== exp_byte[k/10]) begin
                    fails++;
                    $display("FAIL msb_tx_byte c%0d: got %h required %h", k, a_tx_byte, exp_byte[k/10]);
                end
            end
            tests++;
            if (a_sda_oe !== sda_exp) begin
                fails++;
                $display("FAIL msb_sda_oe c%0d: got %b required %b", k, a_sda_oe, sda_exp);
            end
            tests++;
            if ({a_done, a_nacked, a_busy} !== {(k == 40), 1'b0, (k < 40)}) begin
                fails++;
                $display("FAIL msb_done_nacked_busy c%0d: got %b required %b", k,
                         {a_done, a_nacked, a_busy}, {(k == 40), 1'b0, (k < 40)});
            end
            if (a_sda_oe) begin
                wire_bits = {wire_bits[30:0], ser_out};
                nbits++;
            end
            if (k < 40) step();
        end
        tests++;
        if (nbits != 32) begin
            fails++;
            $display("FAIL wire_bit_count: got %0d required 32", nbits);
        end
        tests++;
        if (wire_bits !== 32'h811C9DC5) begin
            fails++;
            $display("FAIL wire_sequence: got %h required 811c9dc5", wire_bits);
        end
    endtask

    task automatic test_lsb_order();
        logic [7:0] exp_byte [4];
        exp_byte[0] = 8'h81; exp_byte[1] = 8'h1C; exp_byte[2] = 8'h9D; exp_byte[3] = 8'hC5;
        put_word(32'h811C9DC5, 1'b1);
        step();
        put_word(32'h811C9DC5, 1'b0);
        for (int k = 0; k <= 40; k++) begin
            if (k < 40 && (k % 10) == 3) begin
                tests++;
                if ({b_tx_enable, b_tx_byte} !== {1'b1, exp_byte[k/10]}) begin
                    fails++;
                    $display("FAIL lsb_tx_byte c%0d: got %b/%h required 1/%h", k, b_tx_enable, b_tx_byte, exp_byte[k/10]);
                end
            end
            if (k == 40) begin
                tests++;
                if ({b_done, b_nacked} !== 2'b10) begin
                    fails++;
                    $display("FAIL lsb_done c40: got %b required 10", {b_done, b_nacked});
                end
            end
            if (k < 40) step();
        end
    endtask

    task automatic test_nack();
        put_word(32'h811C9DC5, 1'b1);
        step();
        put_word(32'h811C9DC5, 1'b0);
        for (int k = 0; k <= 30; k++) begin
            ack_in = (k == 19);
            if (k < 20 && a_done !== 1'b0) begin
                tests++;
                fails++;
                $display("FAIL nack_early_done c%0d: got %b required 0", k, a_done);
            end
            if (k == 20) begin
                tests++;
                if ({a_done, a_nacked, ifa.in_ready, a_busy} !== 4'b1110) begin
                    fails++;
                    $display("FAIL nack_pulse c20: got %b required 1110", {a_done, a_nacked, ifa.in_ready, a_busy});
                end
            end
            if (k > 20) begin
                tests++;
                if ({a_done, a_nacked, ifa.in_ready} !== 3'b001) begin
                    fails++;
                    $display("FAIL nack_after c%0d: got %b required 001", k, {a_done, a_nacked, ifa.in_ready});
                end
            end
            if (k >= 20) begin
                tests++;
                if (a_tx_enable !== 1'b0) begin
                    fails++;
                    $display("FAIL nack_no_more_bytes c%0d: got %b required 0", k, a_tx_enable);
                end
            end
            if (k < 30) step();
        end
        ack_in = 1'b0;
    endtask

    task automatic test_abort();
        put_word(32'h811C9DC5, 1'b1);
        step();
        put_word(32'h811C9DC5, 1'b0);
        for (int k = 0; k < 24; k++) step();
        tests++;
        if ({a_tx_enable, a_tx_byte, a_sda_oe} !== {1'b1, 8'hB9, 1'b1}) begin
            fails++;
            $display("FAIL abort_pre c24: got %b/%h/%b required 1/b9/1", a_tx_enable, a_tx_byte, a_sda_oe);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        tests++;
        if ({a_tx_enable, a_sda_oe, a_busy, ifa.in_ready, a_done, a_nacked} !== 6'b000100) begin
            fails++;
            $display("FAIL abort_post: got %b required 000100",
                     {a_tx_enable, a_sda_oe, a_busy, ifa.in_ready, a_done, a_nacked});
        end
        for (int k = 0; k < 10; k++) begin
            step();
            tests++;
            if ({a_done, a_tx_enable} !== 2'b00) begin
                fails++;
                $display("FAIL abort_quiet[%0d]: got %b required 00", k, {a_done, a_tx_enable});
            end
        end
        put_word(32'h01020304, 1'b1);
        step();
        put_word(32'h01020304, 1'b0);
        tests++;
        if ({a_tx_enable, a_tx_byte} !== {1'b1, 8'h80}) begin
            fails++;
            $display("FAIL abort_new_word: got %b/%h required 1/80", a_tx_enable, a_tx_byte);
        end
        clear_with_abort();
    endtask

    task automatic test_back_to_back();
        put_word(32'h811C9DC5, 1'b1);
        step();
        put_word(32'hDEADBEEF, 1'b1);
        for (int k = 1; k <= 40; k++) begin
            step();
            if (k == 1 || k == 20 || k == 39) begin
                tests++;
                if (ifa.in_ready !== 1'b0) begin
                    fails++;
                    $display("FAIL b2b_ready_busy c%0d: got %b required 0", k, ifa.in_ready);
                end
            end
        end
        tests++;
        if ({a_done, ifa.in_ready, a_busy} !== 3'b110) begin
            fails++;
            $display("FAIL b2b_done_cycle: got %b required 110", {a_done, ifa.in_ready, a_busy});
        end
        step();
        put_word(32'hDEADBEEF, 1'b0);
        tests++;
        if ({a_tx_enable, a_tx_byte, a_busy} !== {1'b1, 8'h7B, 1'b1}) begin
            fails++;
            $display("FAIL b2b_second_first_byte: got %b/%h/%b required 1/7b/1", a_tx_enable, a_tx_byte, a_busy);
        end
        tests++;
        if ({b_tx_enable, b_tx_byte} !== {1'b1, 8'hDE}) begin
            fails++;
            $display("FAIL b2b_second_first_byte_lsb: got %b/%h required 1/de", b_tx_enable, b_tx_byte);
        end
        clear_with_abort();
    endtask

    initial begin
        test_reset();
        test_msb_order();
        test_lsb_order();
        test_nack();
        test_abort();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
